// File: rtl/hazard_pkg.sv
// Shared definitions for the RV32I pipeline control / hazard unit:
// opcode constants, fetch-select encodings, FSM states and the scoreboard entry.
package hazard_pkg;

    // RV32I major opcodes (inst[6:0])
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    // Fetch mux select encodings
    localparam logic [1:0] PC_JAL  = 2'd0;
    localparam logic [1:0] PC_ALU  = 2'd1;
    localparam logic [1:0] PC_P4   = 2'd2;
    localparam logic [1:0] PC_HOLD = 2'd3;

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StFlush
    } hz_state_e;

    // One in-flight instruction past decode; valid=0 marks a bubble
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       writes_rd;
        logic       is_load;
        logic       is_jalr;
        logic       is_branch;
    } sb_entry_t;

endpackage

// File: rtl/inst_class_decode.sv
// Purely combinational classification of an RV32I instruction into the
// register-usage and control-flow flags the hazard unit needs.
module inst_class_decode
    import hazard_pkg::*;
(
    input  logic [31:0] inst,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        writes_rd,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        is_load,
    output logic        is_jalr,
    output logic        is_branch,
    output logic        is_jal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_bits;

    assign opcode      = inst[6:0];
    assign funct3      = inst[14:12];
    assign rd          = inst[11:7];
    assign rs1         = inst[19:15];
    assign rs2         = inst[24:20];
    assign unused_bits = ^inst[31:25];

    // Decode class flags from the opcode; x0 is never a real destination
    always_comb begin
        writes_rd = 1'b0;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b0;
        is_load   = 1'b0;
        is_jalr   = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b0;
            end
            OP_JAL: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b0;
                is_jal    = 1'b1;
            end
            OP_JALR: begin
                writes_rd = 1'b1;
                is_jalr   = (funct3 == 3'b000);
            end
            OP_REG: begin
                writes_rd = 1'b1;
                uses_rs2  = 1'b1;
            end
            OP_IMM: begin
                writes_rd = 1'b1;
            end
            OP_LOAD: begin
                writes_rd = 1'b1;
                is_load   = 1'b1;
            end
            OP_STORE: begin
                uses_rs2  = 1'b1;
            end
            OP_BRANCH: begin
                uses_rs2  = 1'b1;
                is_branch = 1'b1;
            end
            default: ;
        endcase
        if (rd == 5'd0) begin
            writes_rd = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline control and hazard unit for the RV32I core. Tracks in-flight
// destinations in a FWD_DEPTH-entry scoreboard and produces PC select,
// forwarding selects, load-use stalls, memory-wait freezes and redirect flushes.
// Optional: define HAZARD_PERF_CNT_EN to add saturating stall/flush counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned FWD_DEPTH    = 2,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned SEL_W        = $clog2(FWD_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst_fd,
    input  logic             fd_valid,
    input  logic             br_taken_x,
    input  logic             mem_busy,
    output logic [1:0]       pc_sel,
    output logic             stall_fd,
    output logic             freeze,
    output logic             flush_fd,
    output logic [SEL_W-1:0] fwd_a_sel,
    output logic [SEL_W-1:0] fwd_b_sel
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      flush_cnt
`endif
);

    localparam int unsigned CNT_W    = $clog2(FLUSH_CYCLES + 1);
    localparam int          LAST_IDX = int'(FWD_DEPTH) - 1;

    // Decoded view of the FD instruction
    logic [4:0] dec_rd, dec_rs1, dec_rs2;
    logic       dec_writes_rd, dec_uses_rs1, dec_uses_rs2;
    logic       dec_is_load, dec_is_jalr, dec_is_branch, dec_is_jal;

    inst_class_decode u_decode (
        .inst      (inst_fd),
        .rd        (dec_rd),
        .rs1       (dec_rs1),
        .rs2       (dec_rs2),
        .writes_rd (dec_writes_rd),
        .uses_rs1  (dec_uses_rs1),
        .uses_rs2  (dec_uses_rs2),
        .is_load   (dec_is_load),
        .is_jalr   (dec_is_jalr),
        .is_branch (dec_is_branch),
        .is_jal    (dec_is_jal)
    );

    sb_entry_t  sb_q [FWD_DEPTH];
    sb_entry_t  sb_d [FWD_DEPTH];
    sb_entry_t  fd_entry;
    sb_entry_t  new_entry;
    logic       shift_en;

    hz_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       use_a, use_b;
    logic       lu_a, lu_b;
    logic       load_use;
    logic       redirect;
    logic       flush_pending;

    function automatic logic sb_hit(input sb_entry_t e, input logic [4:0] rs);
        return e.valid && e.writes_rd && (e.rd == rs);
    endfunction

    // Scoreboard entry for the FD instruction; invalid FD enters as a bubble
    always_comb begin
        fd_entry = '0;
        if (fd_valid) begin
            fd_entry.valid     = 1'b1;
            fd_entry.rd        = dec_rd;
            fd_entry.writes_rd = dec_writes_rd;
            fd_entry.is_load   = dec_is_load;
            fd_entry.is_jalr   = dec_is_jalr;
            fd_entry.is_branch = dec_is_branch;
        end
    end

    assign use_a = fd_valid && dec_uses_rs1 && (dec_rs1 != 5'd0);
    assign use_b = fd_valid && dec_uses_rs2 && (dec_rs2 != 5'd0);

    // Youngest matching producer wins: scan oldest to youngest, last hit sticks
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        lu_a      = 1'b0;
        lu_b      = 1'b0;
        for (int k = LAST_IDX; k >= 0; k--) begin
            if (use_a && sb_hit(sb_q[k], dec_rs1)) begin
                lu_a      = sb_q[k].is_load && (k < LAST_IDX);
                fwd_a_sel = lu_a ? '0 : SEL_W'(k + 1);
            end
            if (use_b && sb_hit(sb_q[k], dec_rs2)) begin
                lu_b      = sb_q[k].is_load && (k < LAST_IDX);
                fwd_b_sel = lu_b ? '0 : SEL_W'(k + 1);
            end
        end
    end

    assign load_use = lu_a || lu_b;
    assign redirect = sb_q[0].valid && (sb_q[0].is_jalr || (sb_q[0].is_branch && br_taken_x));
    // A flush interrupted by mem_busy keeps its count and resumes on exit
    assign flush_pending = (state_q != StRun) && (cnt_q != '0);

    // Next-state and control outputs, in event priority order
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_sel    = PC_P4;
        stall_fd  = 1'b0;
        freeze    = 1'b0;
        flush_fd  = 1'b0;
        shift_en  = 1'b1;
        new_entry = '0;
        if (mem_busy) begin
            state_d  = StMemWait;
            freeze   = 1'b1;
            pc_sel   = PC_HOLD;
            shift_en = 1'b0;
        end else if (redirect) begin
            pc_sel   = PC_ALU;
            flush_fd = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = StFlush;
                cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
            end else begin
                state_d = StRun;
                cnt_d   = '0;
            end
        end else if (flush_pending) begin
            flush_fd = 1'b1;
            cnt_d    = cnt_q - CNT_W'(1);
            state_d  = (cnt_q == CNT_W'(1)) ? StRun : StFlush;
        end else if (load_use) begin
            state_d  = StRun;
            stall_fd = 1'b1;
            pc_sel   = PC_HOLD;
        end else begin
            state_d   = StRun;
            new_entry = fd_entry;
            if (fd_valid && dec_is_jal) begin
                pc_sel = PC_JAL;
            end
        end
    end

    // Scoreboard shift: new entry (or bubble) at 0, everything else ages by one
    always_comb begin
        for (int k = 0; k < int'(FWD_DEPTH); k++) begin
            sb_d[k] = sb_q[k];
        end
        if (shift_en) begin
            sb_d[0] = new_entry;
            for (int k = 1; k < int'(FWD_DEPTH); k++) begin
                sb_d[k] = sb_q[k-1];
            end
        end
    end

    // State registers: scoreboard, FSM, flush counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(FWD_DEPTH); k++) begin
                sb_q[k] <= '0;
            end
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            for (int k = 0; k < int'(FWD_DEPTH); k++) begin
                sb_q[k] <= sb_d[k];
            end
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((stall_fd || freeze) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_fd && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with FWD_DEPTH=2, FLUSH_CYCLES=2.
module tb_hazard_ctrl_unit;

    localparam logic [31:0] ADDI_X5  = 32'h0010_0293; // addi x5,x0,1
    localparam logic [31:0] ADD_X6   = 32'h0052_8333; // add  x6,x5,x5
    localparam logic [31:0] LW_X7    = 32'h0000_2383; // lw   x7,0(x0)
    localparam logic [31:0] ADD_X8   = 32'h0003_8433; // add  x8,x7,x0
    localparam logic [31:0] BEQ      = 32'h0000_0063; // beq  x0,x0,0
    localparam logic [31:0] JALR     = 32'h0000_8067; // jalr x0,0(x1)
    localparam logic [31:0] NOP      = 32'h0000_0013; // addi x0,x0,0
    localparam logic [31:0] ADD_X9Z  = 32'h0000_04B3; // add  x9,x0,x0
    localparam logic [31:0] JAL_X1   = 32'h0000_00EF; // jal  x1,0

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_fd;
    logic        fd_valid;
    logic        br_taken_x;
    logic        mem_busy;
    logic [1:0]  pc_sel;
    logic        stall_fd;
    logic        freeze;
    logic        flush_fd;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    hazard_ctrl_unit #(
        .FWD_DEPTH    (2),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_fd    (inst_fd),
        .fd_valid   (fd_valid),
        .br_taken_x (br_taken_x),
        .mem_busy   (mem_busy),
        .pc_sel     (pc_sel),
        .stall_fd   (stall_fd),
        .freeze     (freeze),
        .flush_fd   (flush_fd),
        .fwd_a_sel  (fwd_a_sel),
        .fwd_b_sel  (fwd_b_sel)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full output vector check: {pc_sel, stall, freeze, flush, fwd_a, fwd_b}
    task automatic check_all(input string tag, input logic [1:0] e_pc, input logic e_st,
                             input logic e_fz, input logic e_fl, input logic [1:0] e_a,
                             input logic [1:0] e_b);
        check(tag, {pc_sel, stall_fd, freeze, flush_fd, fwd_a_sel, fwd_b_sel},
              {e_pc, e_st, e_fz, e_fl, e_a, e_b});
    endtask

    initial begin
        rst_n      = 1'b0;
        inst_fd    = NOP;
        fd_valid   = 1'b0;
        br_taken_x = 1'b0;
        mem_busy   = 1'b0;
        #3;
        check_all("reset_outputs", 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU producer in X forwards to both sources
        inst_fd = ADDI_X5; fd_valid = 1'b1; #1;
        check_all("addi_in_fd", 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        @(negedge clk); inst_fd = ADD_X6; #1;
        check_all("fwd_x_both", 2'd2, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1);

        // Load-use: one stall cycle, then forward from writeback
        @(negedge clk); inst_fd = LW_X7; #1;
        check_all("lw_in_fd", 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        @(negedge clk); inst_fd = ADD_X8; #1;
        check_all("load_use_stall", 2'd3, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        @(negedge clk); #1;
        check_all("after_stall_fwd_wb", 2'd2, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0);

        // Taken branch: two flush cycles
        @(negedge clk); inst_fd = BEQ; #1;
        check_all("beq_in_fd", 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        @(negedge clk); inst_fd = ADDI_X5; br_taken_x = 1'b1; #1;
        check_all("branch_redirect", 2'd1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        @(negedge clk); inst_fd = ADD_X6; br_taken_x = 1'b0; #1;
        check_all("flush_second_cycle", 2'd2, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        @(negedge clk); inst_fd = NOP; #1;
        check_all("flush_done", 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

        // JALR deferred by three cycles of mem_busy
        @(negedge clk); inst_fd = JALR; #1;
        check_all("jalr_in_fd", 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); inst_fd = ADDI_X5; mem_busy = 1'b1; #1;
            check_all("mem_wait_freeze", 2'd3, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
        end
        @(negedge clk); mem_busy = 1'b0; #1;
        check_all("jalr_after_wait", 2'd1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        @(negedge clk); #1;
        check_all("jalr_flush_second", 2'd2, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0);
        @(negedge clk); #1;
        check_all("jalr_flush_done", 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

        // x0 writer then x0 reader: never forwarded
        @(negedge clk); inst_fd = NOP; #1;
        @(negedge clk); inst_fd = ADD_X9Z; #1;
        check_all("x0_no_forward", 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

        // JAL selects PC+imm only when FD is valid
        @(negedge clk); inst_fd = JAL_X1; #1;
        check("jal_pc_sel", {30'd0, pc_sel}, 32'd0);
        fd_valid = 1'b0; #1;
        check("jal_invalid_pc_sel", {30'd0, pc_sel}, 32'd2);

        // Asynchronous reset in the middle of a load-use stall
        @(negedge clk); fd_valid = 1'b1; inst_fd = LW_X7; #1;
        @(negedge clk); inst_fd = ADD_X8; #1;
        check_all("stall_before_reset", 2'd3, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
        #1 rst_n = 1'b0;
        #1;
        check_all("async_reset_mid_stall", 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
        @(negedge clk); rst_n = 1'b1; fd_valid = 1'b0; #1;
        check_all("post_reset_idle", 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
